// File: rtl/decode_writeback.sv
// Decode and write-back stage: decodes register IDs from icode/rA/rB,
// serves two combinational read ports, and commits up to two writes per edge.
module decode_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        Cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM
);

    localparam logic [3:0] RegNone = 4'hF;
    localparam logic [3:0] RegRsp  = 4'h4;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] ICmov   = 4'h2;
    localparam logic [3:0] IIrmov  = 4'h3;
    localparam logic [3:0] IRmmov  = 4'h4;
    localparam logic [3:0] IMrmov  = 4'h5;
    localparam logic [3:0] IOp     = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPush   = 4'hA;
    localparam logic [3:0] IPop    = 4'hB;

    // Function code travels alongside the instruction but is not decoded here.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // 15 architectural registers; ID 15 is "none" and has no storage.
    logic [63:0] regs_q [15];
    logic [63:0] regs_d [15];

    // Decode source and destination register IDs from the instruction code.
    always_comb begin
        srcA = RegNone;
        srcB = RegNone;
        dstE = RegNone;
        dstM = RegNone;
        case (icode)
            ICmov: begin
                srcA = rA;
                dstE = Cnd ? rB : RegNone;
            end
            IIrmov: begin
                dstE = rB;
            end
            IRmmov: begin
                srcA = rA;
                srcB = rB;
            end
            IMrmov: begin
                srcB = rB;
                dstM = rA;
            end
            IOp: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            ICall: begin
                srcB = RegRsp;
                dstE = RegRsp;
            end
            IRet: begin
                srcA = RegRsp;
                srcB = RegRsp;
                dstE = RegRsp;
            end
            IPush: begin
                srcA = rA;
                srcB = RegRsp;
                dstE = RegRsp;
            end
            IPop: begin
                srcA = RegRsp;
                srcB = RegRsp;
                dstE = RegRsp;
                dstM = rA;
            end
            IHalt, INop, IJxx: begin
                // No register traffic.
            end
            default: begin
                // Undefined icodes leave every ID at "none".
            end
        endcase
    end

    // Read ports show pre-edge contents; ID 15 reads as zero.
    always_comb begin
        valA = (srcA == RegNone) ? 64'h0 : regs_q[srcA];
        valB = (srcB == RegNone) ? 64'h0 : regs_q[srcB];
    end

    // Next-state register file: E write first so an M write to the same ID wins.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_d[i] = 64'h0;
            end
        end else if (wb_en) begin
            if (dstE != RegNone) begin
                regs_d[dstE] = valE;
            end
            if (dstM != RegNone) begin
                regs_d[dstM] = valM;
            end
        end
    end

    // Commit the register file on the rising edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: a behavioural register-file model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_decode_writeback;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        Cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;

    int checks;
    int errors;
    bit check_en;

    logic [63:0] model_regs [16];

    decode_writeback dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .ifun  (ifun),
        .rA    (rA),
        .rB    (rB),
        .Cnd   (Cnd),
        .valE  (valE),
        .valM  (valM),
        .wb_en (wb_en),
        .valA  (valA),
        .valB  (valB),
        .srcA  (srcA),
        .srcB  (srcB),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decode: membership of icode in each rule's set.
    function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb,
                                          input logic c);
        if (ic inside {4'h3, 4'h6}) return rb;
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] id);
        if (id == 4'hF) return 64'h0;
        return model_regs[id];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: reset clears, otherwise E then M (M wins on the same ID).
    always @(posedge clk) begin
        logic [3:0] e;
        logic [3:0] m;
        e = m_dste(icode, rB, Cnd);
        m = m_dstm(icode, rA);
        if (reset) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 64'h0;
        end else if (wb_en) begin
            if (e != 4'hF) model_regs[e] = valE;
            if (m != 4'hF) model_regs[m] = valM;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("srcA", {60'h0, srcA}, {60'h0, m_srca(icode, rA)});
            chk("srcB", {60'h0, srcB}, {60'h0, m_srcb(icode, rB)});
            chk("dstE", {60'h0, dstE}, {60'h0, m_dste(icode, rB, Cnd)});
            chk("dstM", {60'h0, dstM}, {60'h0, m_dstm(icode, rA)});
            chk("valA", valA, m_read(m_srca(icode, rA)));
            chk("valB", valB, m_read(m_srcb(icode, rB)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one instruction's inputs, then settle (still well before the next edge).
    task automatic drive(input logic rst, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic [63:0] ve,
                         input logic [63:0] vm, input logic we);
        reset = rst;
        icode = ic;
        ifun  = 4'h0;
        rA    = ra;
        rB    = rb;
        Cnd   = c;
        valE  = ve;
        valM  = vm;
        wb_en = we;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 64'h0;

        drive(1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        tick();
        check_en = 1'b1;
        tick();

        // OPq decode after reset
        drive(1'b0, 4'h6, 4'h2, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("opq_srcA", {60'h0, srcA}, 64'h2);
        chk("opq_srcB", {60'h0, srcB}, 64'h3);
        chk("opq_dstE", {60'h0, dstE}, 64'h3);
        chk("opq_dstM", {60'h0, dstM}, 64'hF);
        chk("opq_valA", valA, 64'h0);
        chk("opq_valB", valB, 64'h0);
        tick();

        // irmovq rax, then cmov taken / not taken into rcx
        drive(1'b0, 4'h3, 4'hF, 4'h0, 1'b0, 64'h0A, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'h2, 4'h0, 4'h1, 1'b1, 64'h0A, 64'h0, 1'b1);
        chk("cmov_t_dstE", {60'h0, dstE}, 64'h1);
        tick();
        drive(1'b0, 4'h2, 4'h0, 4'h1, 1'b0, 64'h5, 64'h0, 1'b1);
        chk("cmov_nt_dstE", {60'h0, dstE}, 64'hF);
        tick();
        drive(1'b0, 4'h2, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("rcx_after_cmov", valA, 64'h0A);
        tick();

        // popq %rsp: M beats E
        drive(1'b0, 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
        chk("pop_pre_valA", valA, 64'h100);
        chk("pop_pre_valB", valB, 64'h100);
        tick();
        drive(1'b0, 4'h2, 4'h4, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("pop_rsp", valA, 64'h55);
        tick();

        // pushq rdx
        drive(1'b0, 4'h3, 4'hF, 4'h2, 1'b0, 64'h7, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'hA, 4'h2, 4'hF, 1'b0, 64'hF8, 64'h0, 1'b1);
        chk("push_srcA", {60'h0, srcA}, 64'h2);
        chk("push_srcB", {60'h0, srcB}, 64'h4);
        chk("push_dstE", {60'h0, dstE}, 64'h4);
        chk("push_valA", valA, 64'h7);
        chk("push_valB", valB, 64'h100);
        tick();
        drive(1'b0, 4'h2, 4'h4, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("push_rsp", valA, 64'hF8);
        tick();

        // wb_en gating, then reset beating a pending write
        drive(1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'h33, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'hFF, 64'h0, 1'b0);
        tick();
        drive(1'b0, 4'h2, 4'h5, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("rbp_wb_off", valA, 64'h33);
        tick();
        drive(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h1, 64'h0, 1'b1);
        chk("rst_dstE_live", {60'h0, dstE}, 64'h5);
        tick();
        drive(1'b0, 4'h6, 4'h5, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("rbp_after_rst", valA, 64'h0);
        chk("rsp_after_rst", valB, 64'h0);
        tick();

        // nop/halt/undefined: no IDs, no writes across three edges
        drive(1'b0, 4'h3, 4'hF, 4'h0, 1'b0, 64'h11, 64'h0, 1'b1);
        tick();
        drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 64'h99, 64'h77, 1'b1);
        chk("nop_srcA", {60'h0, srcA}, 64'hF);
        chk("nop_dstE", {60'h0, dstE}, 64'hF);
        chk("nop_valA", valA, 64'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 64'h99, 64'h77, 1'b1);
        chk("halt_dstM", {60'h0, dstM}, 64'hF);
        chk("halt_valB", valB, 64'h0);
        tick();
        drive(1'b0, 4'hC, 4'h0, 4'h0, 1'b1, 64'h99, 64'h77, 1'b1);
        chk("undef_srcB", {60'h0, srcB}, 64'hF);
        chk("undef_dstE", {60'h0, dstE}, 64'hF);
        tick();
        drive(1'b0, 4'h6, 4'h0, 4'h1, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("rax_kept", valA, 64'h11);
        chk("rcx_kept", valB, 64'h0);
        tick();

        // mrmovq writes M only
        drive(1'b0, 4'h5, 4'h7, 4'h0, 1'b0, 64'hAAAA, 64'hBEEF, 1'b1);
        tick();
        drive(1'b0, 4'h4, 4'h7, 4'h0, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("mrmov_rdi", valA, 64'hBEEF);
        chk("mrmov_rax", valB, 64'h11);
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
